// File: rtl/dram_arbiter.sv
// dram_arbiter: shares a single-port data RAM (7-bit address, 8-bit data,
// synchronous write, registered synchronous read) between the CPU core and an
// external requester. One access is granted per cycle. Read data returns one
// cycle after the grant with a valid strobe on the port that issued the read.
// Optional build macro DRAM_ARB_RR_EN: when defined, round-robin arbitration
// replaces the fixed-priority / starvation-escape (NORMAL/FORCE) scheme.
module dram_arbiter #(
  parameter int WORD_DEPTH = 70,
  parameter int MAX_WAIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [6:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       ext_req,
  input  logic       ext_we,
  input  logic [6:0] ext_addr,
  input  logic [7:0] ext_din,
  output logic       ext_gnt,
  output logic       ext_rvalid,
  output logic [7:0] ext_rdata,
  output logic [6:0] ram_address,
  output logic       ram_we,
  output logic       ram_re,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  localparam logic [7:0] DEPTH_L = 8'(WORD_DEPTH);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

  logic       cpu_gnt_c, ext_gnt_c;
  logic       any_gnt, sel_we, sel_in_range;
  logic       cpu_in_range, ext_in_range;
  owner_t     rd_owner_p1;
  logic       oor_p1;
  logic [7:0] rd_word;
  logic [7:0] cpu_hold, ext_hold;

`ifdef DRAM_ARB_RR_EN
  logic last_ext;

  // Round-robin: on contention the port that did not win last time goes first.
  always_comb begin
    cpu_gnt_c = 1'b0;
    ext_gnt_c = 1'b0;
    if (!reset) begin
      cpu_gnt_c = cpu_req & (~ext_req | last_ext);
      ext_gnt_c = ext_req & (~cpu_req | ~last_ext);
    end
  end

  // Remember the most recent winner; CPU counts as last winner after reset.
  always_ff @(posedge clk) begin
    if (reset)          last_ext <= 1'b0;
    else if (cpu_gnt_c) last_ext <= 1'b0;
    else if (ext_gnt_c) last_ext <= 1'b1;
  end
`else
  localparam logic [3:0] MAX_L = 4'(MAX_WAIT);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t     state, state_n;
  logic [3:0] wait_cnt, wait_n;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_L) ? MAX_L : v + 4'd1;
  endfunction

  // Fixed CPU priority; a starving external port gets one forced grant.
  always_comb begin
    cpu_gnt_c = 1'b0;
    ext_gnt_c = 1'b0;
    state_n   = state;
    wait_n    = wait_cnt;
    if (!reset) begin
      case (state)
        NORMAL: begin
          cpu_gnt_c = cpu_req;
          ext_gnt_c = ext_req & ~cpu_req;
          if (!ext_req || ext_gnt_c) wait_n = 4'd0;
          else                       wait_n = sat_inc(wait_cnt);
          if (wait_n == MAX_L) state_n = FORCE;
        end
        FORCE: begin
          ext_gnt_c = ext_req;
          state_n   = NORMAL;
          wait_n    = 4'd0;
        end
        default: begin
          state_n = NORMAL;
          wait_n  = 4'd0;
        end
      endcase
    end
  end

  // Arbitration state and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end
`endif

  assign cpu_gnt = cpu_gnt_c;
  assign ext_gnt = ext_gnt_c;

  assign cpu_in_range = {1'b0, cpu_addr} < DEPTH_L;
  assign ext_in_range = {1'b0, ext_addr} < DEPTH_L;

  // RAM port follows the granted requester; CPU inputs when nothing is granted.
  always_comb begin
    any_gnt      = cpu_gnt_c | ext_gnt_c;
    sel_we       = ext_gnt_c ? ext_we       : cpu_we;
    sel_in_range = ext_gnt_c ? ext_in_range : cpu_in_range;
    ram_address  = ext_gnt_c ? ext_addr     : cpu_addr;
    ram_din      = ext_gnt_c ? ext_din      : cpu_din;
    ram_we       = any_gnt & sel_we & sel_in_range;
    ram_re       = any_gnt & ~sel_we & sel_in_range;
  end

  // ---- stage p1: read issued last edge, RAM output valid this cycle ----
  // Track which port owns the read currently coming back from the RAM.
  always_ff @(posedge clk) begin
    if (reset)                   rd_owner_p1 <= OWN_NONE;
    else if (any_gnt && !sel_we) rd_owner_p1 <= ext_gnt_c ? OWN_EXT : OWN_CPU;
    else                         rd_owner_p1 <= OWN_NONE;
  end

  // Out-of-range reads never touched the RAM and return zero instead.
  always_ff @(posedge clk) begin
    oor_p1 <= ~sel_in_range;
  end

  assign rd_word    = oor_p1 ? 8'h00 : ram_dout;
  assign cpu_rvalid = (rd_owner_p1 == OWN_CPU) & ~reset;
  assign ext_rvalid = (rd_owner_p1 == OWN_EXT) & ~reset;
  assign cpu_rdata  = cpu_rvalid ? rd_word : cpu_hold;
  assign ext_rdata  = ext_rvalid ? rd_word : ext_hold;

  // Each port's read data holds its last returned value between reads.
  always_ff @(posedge clk) begin
    if (cpu_rvalid) cpu_hold <= rd_word;
    if (ext_rvalid) ext_hold <= rd_word;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural registered-read RAM.
module tb_dram_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [6:0] cpu_addr, ext_addr;
  logic [7:0] cpu_din, ext_din;
  logic       cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [7:0] cpu_rdata, ext_rdata;
  logic [6:0] ram_address;
  logic       ram_we, ram_re;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [0:127];
  int pass_cnt = 0;
  int total_cnt = 0;

  dram_arbiter #(.WORD_DEPTH(70), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_address(ram_address), .ram_we(ram_we), .ram_re(ram_re),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_address];
  end

  task automatic set_cpu(input logic req, input logic we, input logic [6:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_din = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [6:0] a, input logic [7:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_din = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_cpu(0, 0, 7'h00, 8'h00);
    set_ext(0, 0, 7'h00, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(1, 0, 7'h05, 8'h00);
    set_ext(1, 0, 7'h06, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt actual=%0b expected=0", cpu_gnt); else pass_cnt++;
    total_cnt++; if (ext_gnt !== 1'b0) $display("FAIL rst_ext_gnt actual=%0b expected=0", ext_gnt); else pass_cnt++;
    total_cnt++; if (ram_we !== 1'b0 || ram_re !== 1'b0) $display("FAIL rst_ram_ctl actual=%0b%0b expected=00", ram_we, ram_re); else pass_cnt++;
    total_cnt++; if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) $display("FAIL rst_rvalid actual=%0b%0b expected=00", cpu_rvalid, ext_rvalid); else pass_cnt++;
    idle_cycle();
    reset = 1'b0;
    #1;
    total_cnt++; if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) $display("FAIL rst_rel_rvalid actual=%0b%0b expected=00", cpu_rvalid, ext_rvalid); else pass_cnt++;
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk); set_cpu(1, 1, 7'h20, 8'h5A); #1;
    total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL t1_wr_gnt actual=%0b expected=1", cpu_gnt); else pass_cnt++;
    total_cnt++; if (ram_we !== 1'b1 || ram_address !== 7'h20 || ram_din !== 8'h5A) $display("FAIL t1_wr_port actual=we%0b a%0h d%0h expected=we1 a20 d5a", ram_we, ram_address, ram_din); else pass_cnt++;
    @(negedge clk); set_cpu(1, 0, 7'h20, 8'h00); #1;
    total_cnt++; if (cpu_gnt !== 1'b1 || ram_re !== 1'b1) $display("FAIL t1_rd_gnt actual=gnt%0b re%0b expected=gnt1 re1", cpu_gnt, ram_re); else pass_cnt++;
    total_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL t1_wr_no_rvalid actual=%0b expected=0", cpu_rvalid); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) $display("FAIL t1_rdata actual=v%0b d%0h expected=v1 d5a", cpu_rvalid, cpu_rdata); else pass_cnt++;
    total_cnt++; if (ext_rvalid !== 1'b0) $display("FAIL t1_ext_rvalid actual=%0b expected=0", ext_rvalid); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL t1_rvalid_once actual=%0b expected=0", cpu_rvalid); else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic exp_ext;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_cpu(1, 0, 7'h00, 8'h00);
      set_ext(1, 0, 7'h01, 8'h00);
      #1;
`ifdef DRAM_ARB_RR_EN
      exp_ext = (i % 2 == 0);
`else
      exp_ext = (i == 4);
`endif
      total_cnt++; if (cpu_gnt !== ~exp_ext || ext_gnt !== exp_ext) $display("FAIL t2_cycle%0d actual=cpu%0b ext%0b expected=cpu%0b ext%0b", i, cpu_gnt, ext_gnt, ~exp_ext, exp_ext); else pass_cnt++;
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_cpu(1, 0, 7'h10, 8'h00); set_ext(0, 0, 7'h00, 8'h00); #1;
    total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL t3_cpu_gnt actual=%0b expected=1", cpu_gnt); else pass_cnt++;
    @(negedge clk); set_cpu(0, 0, 7'h00, 8'h00); set_ext(1, 0, 7'h11, 8'h00); #1;
    total_cnt++; if (ext_gnt !== 1'b1 || ram_address !== 7'h11) $display("FAIL t3_ext_gnt actual=g%0b a%0h expected=g1 a11", ext_gnt, ram_address); else pass_cnt++;
    total_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h11 || ext_rvalid !== 1'b0) $display("FAIL t3_cpu_rd actual=v%0b d%0h ev%0b expected=v1 d11 ev0", cpu_rvalid, cpu_rdata, ext_rvalid); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (ext_rvalid !== 1'b1 || ext_rdata !== 8'h22 || cpu_rvalid !== 1'b0) $display("FAIL t3_ext_rd actual=v%0b d%0h cv%0b expected=v1 d22 cv0", ext_rvalid, ext_rdata, cpu_rvalid); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 8'h11) $display("FAIL t3_cpu_hold actual=%0h expected=11", cpu_rdata); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (ext_rvalid !== 1'b0 || ext_rdata !== 8'h22) $display("FAIL t3_ext_hold actual=v%0b d%0h expected=v0 d22", ext_rvalid, ext_rdata); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    @(negedge clk); set_ext(1, 1, 7'h46, 8'hFF); #1;
    total_cnt++; if (ext_gnt !== 1'b1 || ram_we !== 1'b0) $display("FAIL t4_wr actual=g%0b we%0b expected=g1 we0", ext_gnt, ram_we); else pass_cnt++;
    @(negedge clk); set_ext(1, 0, 7'h46, 8'h00); #1;
    total_cnt++; if (ext_gnt !== 1'b1 || ram_re !== 1'b0) $display("FAIL t4_rd actual=g%0b re%0b expected=g1 re0", ext_gnt, ram_re); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (ext_rvalid !== 1'b1 || ext_rdata !== 8'h00) $display("FAIL t4_rdata actual=v%0b d%0h expected=v1 d00", ext_rvalid, ext_rdata); else pass_cnt++;
    total_cnt++; if (mem[70] !== 8'h00) $display("FAIL t4_mem70 actual=%0h expected=00", mem[70]); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_reset_midflight();
    logic exp_ext;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_cpu(1, 0, 7'h00, 8'h00); set_ext(1, 0, 7'h01, 8'h00);
    end
    @(negedge clk); set_cpu(1, 0, 7'h20, 8'h00);
`ifdef DRAM_ARB_RR_EN
    set_ext(0, 0, 7'h00, 8'h00);
`else
    set_ext(1, 0, 7'h01, 8'h00);
`endif
    #1;
    total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL t5_pre_gnt actual=%0b expected=1", cpu_gnt); else pass_cnt++;
    @(negedge clk); reset = 1'b1; set_ext(1, 0, 7'h01, 8'h00); #1;
    total_cnt++; if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) $display("FAIL t5_rvalid actual=%0b%0b expected=00", cpu_rvalid, ext_rvalid); else pass_cnt++;
    total_cnt++; if (cpu_gnt !== 1'b0 || ext_gnt !== 1'b0) $display("FAIL t5_gnt actual=%0b%0b expected=00", cpu_gnt, ext_gnt); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); reset = 1'b0; #1;
      if (i == 0) begin
        total_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL t5_post_rvalid actual=%0b expected=0", cpu_rvalid); else pass_cnt++;
      end
`ifdef DRAM_ARB_RR_EN
      exp_ext = (i % 2 == 0);
`else
      exp_ext = (i == 4);
`endif
      total_cnt++; if (cpu_gnt !== ~exp_ext || ext_gnt !== exp_ext) $display("FAIL t5_post_cycle%0d actual=cpu%0b ext%0b expected=cpu%0b ext%0b", i, cpu_gnt, ext_gnt, ~exp_ext, exp_ext); else pass_cnt++;
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_same_address();
    @(negedge clk); set_cpu(1, 1, 7'h30, 8'hAA); set_ext(1, 1, 7'h30, 8'h55); #1;
    total_cnt++; if (cpu_gnt !== 1'b1 || ext_gnt !== 1'b0 || ram_din !== 8'hAA) $display("FAIL t6_first actual=c%0b e%0b d%0h expected=c1 e0 daa", cpu_gnt, ext_gnt, ram_din); else pass_cnt++;
    @(negedge clk); set_cpu(0, 0, 7'h00, 8'h00); #1;
    total_cnt++; if (ext_gnt !== 1'b1 || ram_we !== 1'b1 || ram_din !== 8'h55) $display("FAIL t6_second actual=e%0b we%0b d%0h expected=e1 we1 d55", ext_gnt, ram_we, ram_din); else pass_cnt++;
    @(negedge clk); set_cpu(1, 0, 7'h30, 8'h00); set_ext(0, 0, 7'h00, 8'h00); #1;
    total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL t6_rd_gnt actual=%0b expected=1", cpu_gnt); else pass_cnt++;
    idle_cycle(); #1;
    total_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h55) $display("FAIL t6_rdata actual=v%0b d%0h expected=v1 d55", cpu_rvalid, cpu_rdata); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'h11;
    mem[7'h11] = 8'h22;
    ram_dout = 8'h00;
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    test_same_address();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
